// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-rate VGA timing generator. A clock-enable divider turns the system
//   clock into a one-clk pixel strobe (p_tick). The x/y counters advance only on
//   that strobe. Sync, blanking and line/frame markers are decoded from the
//   registered counters.
//
//   Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit
//   free-running frame counter output (frame_count).
//
// Ports
//   clk_100MHz  in   system clock, all logic on its rising edge
//   reset       in   synchronous active-high reset, overrides en
//   en          in   timing advance enable; divider, x and y hold while low
//   p_tick      out  pixel strobe, one clk wide
//   x, y        out  horizontal pixel / vertical line counters (CNT_W bits)
//   video_on    out  high inside the visible area
//   hsync       out  horizontal sync, active level HSYNC_POL
//   vsync       out  vertical sync, active level VSYNC_POL
//   line_start  out  one-clk pulse on the tick that wraps x
//   frame_start out  one-clk pulse on the tick that wraps both x and y
//   frame_count out  [15:0] frames completed (only with VGA_TIMING_FRAME_CNT_EN)
//
// Handshake: there is no valid/ready flow. en is a plain level enable sampled
// every clk, and p_tick/line_start/frame_start are single-cycle strobes that
// the consumer must sample in the cycle they are high.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             en,
  output logic             p_tick,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // A 1-bit divider is kept even for CLK_DIV=1; it then never leaves 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DISP_C = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_DISP_C = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Reject configurations the counters cannot represent.
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if ((H_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
  end
  if ((V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
  end

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;

  logic w_tick;
  logic w_line_wrap;
  logic w_frame_wrap;
  logic w_h_active;
  logic w_v_active;
  logic w_in_hsync;
  logic w_in_vsync;

  // reset gates the strobes so they read 0 for the whole reset cycle, even
  // the first one where the counters have not yet been cleared.
  assign w_tick       = en & ~reset & (r_div == DIV_LAST);
  assign w_line_wrap  = w_tick & (r_x == H_LAST);
  assign w_frame_wrap = w_line_wrap & (r_y == V_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_div <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (en) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_x <= w_line_wrap ? '0 : r_x + 1'b1;
      end
      if (w_line_wrap) begin
        r_y <= w_frame_wrap ? '0 : r_y + 1'b1;
      end
    end
  end

  // Decodes read the registered counters so they line up with x/y.
  assign w_h_active = (r_x < H_DISP_C);
  assign w_v_active = (r_y < V_DISP_C);
  assign w_in_hsync = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
  assign w_in_vsync = (r_y >= VS_FIRST) && (r_y <= VS_LAST);

  assign p_tick      = w_tick;
  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = w_h_active && w_v_active;
  assign hsync       = w_in_hsync ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = w_in_vsync ? VSYNC_POL : ~VSYNC_POL;
  assign line_start  = w_line_wrap;
  assign frame_start = w_frame_wrap;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Wraps naturally from 65535 to 0.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_count = r_frame_cnt;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY SHALL default to 640: visible pixels per line.
REQ-002 Parameter H_FRONT SHALL default to 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC SHALL default to 96: hsync pulse width, in pixels.
REQ-004 Parameter H_BACK SHALL default to 48: horizontal back porch, in pixels.
REQ-005 Parameter V_DISPLAY SHALL default to 480: visible lines per frame.
REQ-006 Parameter V_FRONT SHALL default to 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC SHALL default to 2: vsync pulse width, in lines.
REQ-008 Parameter V_BACK SHALL default to 33: vertical back porch, in lines.
REQ-009 Parameter CLK_DIV SHALL default to 4: system clocks per pixel (legal range >=1).
REQ-010 Parameter HSYNC_POL SHALL default to 0: active level of hsync.
REQ-011 Parameter VSYNC_POL SHALL default to 0: active level of vsync.
REQ-012 Parameter CNT_W SHALL default to 10: width of x and y.
REQ-013 Ports SHALL be, in order:
- clk_100MHz  input  1  sole system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  timing advance enable.
- p_tick  output  1  pixel strobe, one clk wide.
- x  output  CNT_W  horizontal pixel count.
- y  output  CNT_W  vertical line count.
- video_on  output  1  high inside the visible area.
- hsync  output  1  horizontal sync, level set by HSYNC_POL.
- vsync  output  1  vertical sync, level set by VSYNC_POL.
- line_start  output  1  one-clk pulse on the tick that wraps x.
- frame_start  output  1  one-clk pulse on the tick that wraps both x and y.

Function
REQ-014 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK, and V_TOTAL SHALL equal the corresponding V sum.
REQ-015 The divider SHALL count 0..CLK_DIV-1 while en=1.
REQ-016 p_tick SHALL equal en AND (divider==CLK_DIV-1); with CLK_DIV=1, p_tick SHALL equal en in every cycle.
REQ-017 On p_tick, x SHALL increment and wrap from H_TOTAL-1 to 0; on that wrap, y SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-018 While en=0, the divider, x and y SHALL hold, and p_tick, line_start and frame_start SHALL be 0.
REQ-019 video_on SHALL be (x<H_DISPLAY)&&(y<V_DISPLAY), decoded combinationally from the registered counters so it aligns with x and y in the same cycle.
REQ-020 hsync SHALL be HSYNC_POL for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] and ~HSYNC_POL otherwise.
REQ-021 vsync SHALL be VSYNC_POL for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] and ~VSYNC_POL otherwise.
REQ-022 line_start SHALL equal p_tick && x==H_TOTAL-1.
REQ-023 frame_start SHALL equal line_start && y==V_TOTAL-1, so that x=0 and y=0 in the following cycle.
REQ-024 The divider width SHALL be $clog2(CLK_DIV), with a minimum of 1.
REQ-025 Elaboration SHALL fail if CLK_DIV<1, if H_TOTAL-1>=2**CNT_W, or if V_TOTAL-1>=2**CNT_W.

Reset
REQ-026 While reset=1, the following SHALL hold:
- divider, x and y = 0;
- p_tick, line_start and frame_start = 0;
- video_on = 1 (given non-zero H_DISPLAY and V_DISPLAY);
- hsync = ~HSYNC_POL and vsync = ~VSYNC_POL.
REQ-027 reset SHALL override en, and a reset asserted mid-frame SHALL return x=0 and y=0 at the next edge.
REQ-028 With en=1, the first p_tick after reset SHALL occur in the CLK_DIV-th cycle after reset is sampled low.

Configuration
REQ-029 With VGA_TIMING_FRAME_CNT_EN defined:
- an output frame_count[15:0] SHALL exist;
- it SHALL reset to 0;
- it SHALL increment at the edge where frame_start=1 and wrap from 65535 to 0.
REQ-030 Without VGA_TIMING_FRAME_CNT_EN, the frame_count port and its counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Defaults; reset for 10 clk, then en=1 -> p_tick on every 4th clk; x runs 0..799 then wraps to 0; y becomes 1; line period = 3200 clk.
REQ-032 Defaults -> hsync=0 exactly for x=656..751 (384 clk); video_on=0 for x>=640.
REQ-033 Defaults -> vsync=0 for y=490..491 (6400 clk); frame_start exactly once per 1,680,000 clk (16.8 ms).
REQ-034 Defaults; en=0 for 100 clk at x=300 -> x holds at 300 with p_tick=0; after en returns to 1, x reaches 301 within 4 clk.
REQ-035 Defaults; reset pulsed at x=700, y=400 -> next edge gives x=0, y=0, hsync=1, vsync=1, video_on=1.
REQ-036 Parameters CLK_DIV=1, H=8/2/2/4, V=4/1/1/2, HSYNC_POL=1, macro defined -> p_tick=1 every clk; hsync=1 at x=10..11; frame = 128 clk; frame_count increments every 128 clk.
